// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises and filters ps2_clk, deserialises 11-bit frames into scancode + enable strobe.
// Optional macro PS2_PARITY_CHECK_EN turns a parity mismatch into a discarded frame.
module ps2_scancode_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       enable,
    output logic       frame_err,
    output logic       busy
);

    localparam int FCW = $clog2(FILTER_LEN) + 1;
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FCW-1:0] FLT_MAX = FCW'(FILTER_LEN - 1);
    localparam logic [TW-1:0]  TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic [FCW-1:0]         flt_cnt;
    logic                   clk_flt;
    logic                   clk_flt_d;
    logic                   fall;
    logic                   data_s;

    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift, shift_n;
    logic [7:0] scancode_n;
    logic [TW-1:0] tmo_cnt, tmo_cnt_n;
    logic       enable_n, frame_err_n;
    logic       tmo_hit;
    logic       good;
`ifdef PS2_PARITY_CHECK_EN
    logic       parity_bit, parity_bit_n;
`endif

    // Input conditioning: synchronisers, then a level filter on the clock line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            flt_cnt   <= '0;
            clk_flt   <= 1'b1;
            clk_flt_d <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_flt_d <= clk_flt;
            if (clk_sync[SYNC_STAGES-1] != clk_flt) begin
                if (flt_cnt == FLT_MAX) begin
                    clk_flt <= clk_sync[SYNC_STAGES-1];
                    flt_cnt <= '0;
                end else begin
                    flt_cnt <= flt_cnt + 1'b1;
                end
            end else begin
                flt_cnt <= '0;
            end
        end
    end

    assign fall    = clk_flt_d & ~clk_flt;
    assign data_s  = data_sync[SYNC_STAGES-1];
    assign busy    = (state != IDLE);
    assign tmo_hit = busy && (tmo_cnt == TMO_MAX);

    // Frame FSM: state and strobe registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            tmo_cnt   <= '0;
            scancode  <= 8'h00;
            enable    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            tmo_cnt   <= tmo_cnt_n;
            scancode  <= scancode_n;
            enable    <= enable_n;
            frame_err <= frame_err_n;
        end
    end

    always_ff @(posedge clk) begin
        shift <= shift_n;
`ifdef PS2_PARITY_CHECK_EN
        parity_bit <= parity_bit_n;
`endif
    end

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift;
        scancode_n  = scancode;
        tmo_cnt_n   = busy ? tmo_cnt + 1'b1 : '0;
        enable_n    = 1'b0;
        frame_err_n = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        parity_bit_n = parity_bit;
        good = data_s && (^{shift, parity_bit});
`else
        good = data_s;
`endif
        // Timeout takes priority over a coincident fall event
        if (tmo_hit) begin
            state_n     = IDLE;
            bit_cnt_n   = '0;
            tmo_cnt_n   = '0;
            frame_err_n = 1'b1;
        end else if (fall) begin
            tmo_cnt_n = '0;
            case (state)
                IDLE: begin
                    if (!data_s) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                    end
                end
                DATA: begin
                    shift_n[bit_cnt] = data_s;
                    bit_cnt_n        = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) state_n = PARITY;
                end
                PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    parity_bit_n = data_s;
`endif
                    state_n = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (good) begin
                        scancode_n = shift;
                        enable_n   = 1'b1;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule
